dpic_cmd_responder: RTL and testbench

- Synthesizable responder end of the byte-per-tick command channel that the DPI-C host model drives from the testbench.
- Receives 5-byte command frames (SOF, opcode, two operands, checksum) from the host byte stream.
- Executes a small ALU operation and returns a 4-byte response frame.
- Sits between the bench-side DPI byte exchange and DUT logic; also used standalone to validate the host model's framing.

---
 rtl/dpic_cmd_responder.sv | 197 +++++++++++++++++++
 tb/tb_dpic_cmd_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpic_cmd_responder.sv
// Responder end of the byte-per-tick DPI-C command channel: parses 5-byte command
// frames, executes a small ALU operation and returns a 4-byte response frame.
module dpic_cmd_responder #(
   parameter logic [7:0] SOF_CMD = 8'hA5,
   parameter logic [7:0] SOF_RSP = 8'h5A,
   parameter int         TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [15:0] frame_cnt,
   output logic [7:0]  err_cnt
);

   typedef enum logic [3:0] {
      st_idle,
      st_op,
      st_opa,
      st_opb,
      st_chk,
      st_exec,
      st_tx_sof,
      st_tx_st,
      st_tx_res,
      st_tx_chk
   } state_t;

   localparam logic [7:0] OP_ADD     = 8'h01;
   localparam logic [7:0] OP_SUB     = 8'h02;
   localparam logic [7:0] OP_XOR     = 8'h03;
   localparam logic [7:0] OP_CNT     = 8'h04;
   localparam logic [7:0] ST_OK      = 8'h00;
   localparam logic [7:0] ST_BAD_OP  = 8'h01;
   localparam logic [7:0] ST_BAD_CHK = 8'h02;
   localparam logic [7:0] TOUT_LAST  = 8'(TIMEOUT - 1);

   state_t     state_reg;
   logic [7:0] op_reg;
   logic [7:0] a_reg;
   logic [7:0] b_reg;
   logic [7:0] chk_reg;
   logic [7:0] status_reg;
   logic [7:0] result_reg;
   logic [7:0] tcnt_reg;

   logic       rx_fire;
   logic       tx_fire;
   logic [7:0] exec_status;
   logic [7:0] exec_result;
   logic       exec_good;

   assign rx_fire = rx_valid && rx_ready;
   assign tx_fire = tx_valid && tx_ready;

   // Checksum is judged before the opcode, so a corrupted frame never executes.
   always_comb begin
      exec_status = ST_OK;
      exec_result = 8'h00;
      exec_good   = 1'b0;
      if (chk_reg != (op_reg ^ a_reg ^ b_reg)) begin
         exec_status = ST_BAD_CHK;
      end else begin
         unique case (op_reg)
            OP_ADD: begin
               exec_result = a_reg + b_reg;
               exec_good   = 1'b1;
            end
            OP_SUB: begin
               exec_result = a_reg - b_reg;
               exec_good   = 1'b1;
            end
            OP_XOR: begin
               exec_result = a_reg ^ b_reg;
               exec_good   = 1'b1;
            end
            OP_CNT: begin
               exec_result = frame_cnt[7:0];
               exec_good   = 1'b1;
            end
            default: begin
               exec_status = ST_BAD_OP;
            end
         endcase
      end
   end

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= st_idle;
         rx_ready   <= 1'b1;
         tx_valid   <= 1'b0;
         tx_byte    <= 8'h00;
         frame_cnt  <= 16'h0000;
         err_cnt    <= 8'h00;
         tcnt_reg   <= 8'h00;
         op_reg     <= 8'h00;
         a_reg      <= 8'h00;
         b_reg      <= 8'h00;
         chk_reg    <= 8'h00;
         status_reg <= 8'h00;
         result_reg <= 8'h00;
      end else begin
         unique case (state_reg)
            st_idle: begin
               tcnt_reg <= 8'h00;
               if (rx_fire && rx_byte == SOF_CMD) begin
                  state_reg <= st_op;
               end
            end
            st_op, st_opa, st_opb, st_chk: begin
               if (rx_fire) begin
                  tcnt_reg <= 8'h00;
                  unique case (state_reg)
                     st_op: begin
                        op_reg    <= rx_byte;
                        state_reg <= st_opa;
                     end
                     st_opa: begin
                        a_reg     <= rx_byte;
                        state_reg <= st_opb;
                     end
                     st_opb: begin
                        b_reg     <= rx_byte;
                        state_reg <= st_chk;
                     end
                     default: begin
                        chk_reg   <= rx_byte;
                        rx_ready  <= 1'b0;
                        state_reg <= st_exec;
                     end
                  endcase
               end else if (tcnt_reg == TOUT_LAST) begin
                  // Host stalled mid-frame: discard the partial frame silently.
                  tcnt_reg  <= 8'h00;
                  err_cnt   <= sat_inc(err_cnt);
                  state_reg <= st_idle;
               end else begin
                  tcnt_reg <= tcnt_reg + 8'd1;
               end
            end
            st_exec: begin
               status_reg <= exec_status;
               result_reg <= exec_result;
               if (exec_good) begin
                  frame_cnt <= frame_cnt + 16'd1;
               end else begin
                  err_cnt <= sat_inc(err_cnt);
               end
               tx_valid  <= 1'b1;
               tx_byte   <= SOF_RSP;
               state_reg <= st_tx_sof;
            end
            st_tx_sof: begin
               if (tx_fire) begin
                  tx_byte   <= status_reg;
                  state_reg <= st_tx_st;
               end
            end
            st_tx_st: begin
               if (tx_fire) begin
                  tx_byte   <= result_reg;
                  state_reg <= st_tx_res;
               end
            end
            st_tx_res: begin
               if (tx_fire) begin
                  tx_byte   <= status_reg ^ result_reg;
                  state_reg <= st_tx_chk;
               end
            end
            st_tx_chk: begin
               if (tx_fire) begin
                  tx_valid  <= 1'b0;
                  tx_byte   <= 8'h00;
                  rx_ready  <= 1'b1;
                  state_reg <= st_idle;
               end
            end
            default: begin
               state_reg <= st_idle;
               rx_ready  <= 1'b1;
               tx_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dpic_cmd_responder.sv
// Scoreboard bench for dpic_cmd_responder: a frame-level reference model queues the
// expected response bytes, and an independent monitor checks every transfer.
module tb_dpic_cmd_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_byte = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic [15:0] frame_cnt;
   logic [7:0]  err_cnt;

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_q[$];
   logic [15:0] m_frame = 16'h0;
   logic [7:0]  m_err = 8'h0;

   bit          mon_en = 1'b1;
   bit          held_valid = 1'b0;
   logic [7:0]  held_byte = 8'h0;
   int          tx_xfers = 0;
   int          rdy_mode = 0;
   int          pat_i = 0;
   int          pat[7] = '{1, 0, 0, 1, 0, 1, 1};

   dpic_cmd_responder #(.SOF_CMD(8'hA5), .SOF_RSP(8'h5A), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .frame_cnt(frame_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic chk8(input string name, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, got, want);
      end
   endtask

   // Host-side ready pattern generator.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = 1'($urandom_range(0, 1));
            default: begin
               if (tx_valid) begin
                  tx_ready = (pat_i < 7) ? 1'(pat[pat_i]) : 1'b1;
                  pat_i++;
               end else begin
                  tx_ready = 1'b1;
               end
            end
         endcase
      end
   end

   // Monitor: samples at the falling edge, predicting what the next rising edge transfers.
   always @(negedge clk) begin
      if (!rst && mon_en) begin
         if (held_valid) begin
            checks++;
            if (tx_byte !== held_byte) begin
               errors++;
               $display("FAIL tx_stable: got %h required %h", tx_byte, held_byte);
            end
         end
         held_valid = tx_valid && !tx_ready;
         held_byte  = tx_byte;
         if (tx_valid) begin
            checks++;
            if (rx_ready !== 1'b0) begin
               errors++;
               $display("FAIL rx_ready_during_tx: got %b required 0", rx_ready);
            end
            if (tx_ready) begin
               checks++;
               tx_xfers++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_tx: got byte %h required no transfer", tx_byte);
               end else begin
                  logic [7:0] e;
                  e = exp_q.pop_front();
                  if (tx_byte !== e) begin
                     errors++;
                     $display("FAIL tx_byte: got %h required %h", tx_byte, e);
                  end else begin
                     $display("tx byte %h ok", tx_byte);
                  end
               end
            end
         end
      end
   end

   // Frame-level reference: status/result from the opcode table, counters updated in order.
   task automatic model_frame(input logic [7:0] op, a, b, chk);
      logic [7:0] st;
      logic [7:0] res;
      st  = 8'h00;
      res = 8'h00;
      if (chk != (op ^ a ^ b)) begin
         st = 8'h02;
      end else if (op == 8'h01) begin
         res = a + b;
      end else if (op == 8'h02) begin
         res = a - b;
      end else if (op == 8'h03) begin
         res = a ^ b;
      end else if (op == 8'h04) begin
         res = m_frame[7:0];
      end else begin
         st = 8'h01;
      end
      if (st == 8'h00) m_frame = m_frame + 16'd1;
      else if (m_err != 8'hFF) m_err = m_err + 8'd1;
      exp_q.push_back(8'h5A);
      exp_q.push_back(st);
      exp_q.push_back(res);
      exp_q.push_back(st ^ res);
      $display("cmd op=%h a=%h b=%h chk=%h -> rsp 5A %h %h %h", op, a, b, chk, st, res, st ^ res);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_byte  = b;
      rx_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (rx_ready) break;
         n++;
         if (n > 200) break;
      end
      if (n > 200) begin
         checks++;
         errors++;
         $display("FAIL rx_accept_timeout: got rx_ready 0 for 200 cycles, required 1");
         rx_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         rx_valid = 1'b0;
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] op, a, b, chk, input int gap_max, input bit push);
      if (push) model_frame(op, a, b, chk);
      send_byte(8'hA5);
      idle_cycles($urandom_range(0, gap_max));
      send_byte(op);
      idle_cycles($urandom_range(0, gap_max));
      send_byte(a);
      idle_cycles($urandom_range(0, gap_max));
      send_byte(b);
      idle_cycles($urandom_range(0, gap_max));
      send_byte(chk);
   endtask

   task automatic drain_and_check();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || tx_valid) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL drain: got %0d bytes still pending, required 0", exp_q.size());
         exp_q.delete();
      end
      chk8("frame_cnt", frame_cnt, m_frame);
      chk8("err_cnt", {8'h0, err_cnt}, {8'h0, m_err});
      chk8("rx_ready_idle", {15'h0, rx_ready}, 16'h1);
   endtask

   initial begin
      logic [7:0] op, a, b, c, g;
      #12;
      chk8("rst_rx_ready", {15'h0, rx_ready}, 16'h1);
      chk8("rst_tx_valid", {15'h0, tx_valid}, 16'h0);
      chk8("rst_tx_byte", {8'h0, tx_byte}, 16'h0);
      chk8("rst_frame_cnt", frame_cnt, 16'h0);
      chk8("rst_err_cnt", {8'h0, err_cnt}, 16'h0);
      #5 rst = 1'b0;
      idle_cycles(2);

      // First ADD frame plus latency: EXEC cycle, then SOF_RSP one edge later.
      send_frame(8'h01, 8'h06, 8'h03, 8'h04, 0, 1);
      chk8("lat_exec_no_valid", {15'h0, tx_valid}, 16'h0);
      @(posedge clk);
      #1;
      chk8("lat_sof_valid", {15'h0, tx_valid}, 16'h1);
      chk8("lat_sof_byte", {8'h0, tx_byte}, 16'h005A);
      drain_and_check();

      send_frame(8'h02, 8'h03, 8'h06, 8'h07, 2, 1);
      drain_and_check();
      send_frame(8'h04, 8'h00, 8'h00, 8'h04, 2, 1);
      drain_and_check();

      send_frame(8'h01, 8'h06, 8'h03, 8'h00, 1, 1);
      drain_and_check();
      send_frame(8'h07, 8'h01, 8'h01, 8'h07, 1, 1);
      drain_and_check();

      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h13);
      send_frame(8'h03, 8'hF0, 8'h0F, 8'hFC, 0, 1);
      drain_and_check();

      // Timeout boundary: 15 silent cycles keep the frame, the 16th aborts it.
      send_byte(8'hA5);
      send_byte(8'h01);
      idle_cycles(15);
      chk8("tout_before", {8'h0, err_cnt}, {8'h0, m_err});
      idle_cycles(1);
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      chk8("tout_after", {8'h0, err_cnt}, {8'h0, m_err});
      idle_cycles(4);
      chk8("tout_no_tx", {15'h0, tx_valid}, 16'h0);
      send_frame(8'h01, 8'h10, 8'h20, 8'h31, 0, 1);
      drain_and_check();

      // Back-pressure pattern on the response.
      rdy_mode = 2;
      pat_i    = 0;
      tx_xfers = 0;
      send_frame(8'h01, 8'h22, 8'h33, 8'h10, 0, 1);
      drain_and_check();
      chk8("stall_xfers", 16'(tx_xfers), 16'd4);
      rdy_mode = 0;

      // Reset while the result byte is on the wire.
      mon_en = 1'b0;
      send_frame(8'h01, 8'h06, 8'h03, 8'h04, 0, 0);
      idle_cycles(3);
      chk8("mid_tx_res_byte", {8'h0, tx_byte}, 16'h0009);
      #2 rst = 1'b1;
      #1;
      chk8("arst_tx_valid", {15'h0, tx_valid}, 16'h0);
      chk8("arst_frame_cnt", frame_cnt, 16'h0);
      chk8("arst_err_cnt", {8'h0, err_cnt}, 16'h0);
      chk8("arst_rx_ready", {15'h0, rx_ready}, 16'h1);
      m_frame = 16'h0;
      m_err   = 8'h0;
      #3 rst = 1'b0;
      held_valid = 1'b0;
      mon_en     = 1'b1;
      idle_cycles(1);
      send_frame(8'h01, 8'h06, 8'h03, 8'h04, 0, 1);
      drain_and_check();

      // Randomized frames with garbage prefixes, gaps and random back-pressure.
      for (int i = 0; i < 40; i++) begin
         rdy_mode = int'($urandom_range(0, 1));
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h00;
            send_byte(g);
         end
         case ($urandom_range(0, 4))
            0: op = 8'h01;
            1: op = 8'h02;
            2: op = 8'h03;
            3: op = 8'h04;
            default: op = 8'($urandom);
         endcase
         a = 8'($urandom);
         b = 8'($urandom);
         c = op ^ a ^ b;
         if ($urandom_range(0, 4) == 0) c = c ^ 8'($urandom_range(1, 255));
         send_frame(op, a, b, c, 3, 1);
         drain_and_check();
      end
      rdy_mode = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
